tx_width_sequencer: RTL and testbench

TX_WIDTH_SEQUENCER -- requirements
Module: tx_width_sequencer

---
 rtl/tx_width_sequencer_if.sv | 27 ++
 rtl/tx_width_sequencer.sv | 110 +++++++++++
 tb/tb_tx_width_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/tx_width_sequencer_if.sv
// MAC-to-encoder bus for tx_width_sequencer: MAC word input, serialized byte
// output and status. The master side drives the MAC word; the slave is the sequencer.
interface tx_width_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int K_WIDTH    = 4
);
    logic [5:0]            DataBusWidth;
    logic [DATA_WIDTH-1:0] MAC_TX_Data;
    logic [K_WIDTH-1:0]    MAC_TX_DataK;
    logic                  MAC_Data_En;
    logic                  MAC_Data_Rdy;
    logic [7:0]            Enc_Data;
    logic                  Enc_DataK;
    logic                  Enc_Data_En;
    logic                  Width_Err;
    logic [15:0]           Word_Cnt;

    modport master (
        output DataBusWidth, MAC_TX_Data, MAC_TX_DataK, MAC_Data_En,
        input  MAC_Data_Rdy, Enc_Data, Enc_DataK, Enc_Data_En, Width_Err, Word_Cnt
    );

    modport slave (
        input  DataBusWidth, MAC_TX_Data, MAC_TX_DataK, MAC_Data_En,
        output MAC_Data_Rdy, Enc_Data, Enc_DataK, Enc_Data_En, Width_Err, Word_Cnt
    );
endinterface

// File: rtl/tx_width_sequencer.sv
// Serializes an 8/16/32-bit MAC word (with per-byte K flags) into a byte stream
// for an 8b/10b encoder, one byte per PCLK, back-to-back words without gaps.
module tx_width_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int K_WIDTH    = 4
) (
    input  logic PCLK,
    input  logic Reset,
    tx_width_sequencer_if.slave bus
);
    localparam int IDX_W = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [IDX_W-1:0]      hold_last, last_sel;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [K_WIDTH-1:0]    hold_k;
    logic [15:0]           word_cnt;
    logic                  width_err;
    logic                  legal, rdy, accept, at_last, load;

    // Width decode: last byte index of a word at the current bus width.
    always_comb begin
        legal    = 1'b0;
        last_sel = '0;
        case (bus.DataBusWidth)
            6'd8:  begin legal = 1'b1;          last_sel = '0;          end
            6'd16: begin legal = (K_WIDTH >= 2); last_sel = IDX_W'(1); end
            6'd32: begin legal = (K_WIDTH >= 4); last_sel = IDX_W'(3); end
            default: begin legal = 1'b0;        last_sel = '0;          end
        endcase
    end

    assign at_last = (idx == hold_last);
    assign rdy     = ((state == IDLE) || at_last) && legal && !Reset;
    assign accept  = bus.MAC_Data_En && rdy;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load      = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (!at_last) begin
                    idx_nxt = idx + 1'b1;
                end else if (accept) begin
                    load    = 1'b1;
                    idx_nxt = '0;
                end else begin
                    idx_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            idx       <= '0;
            hold_data <= '0;
            hold_k    <= '0;
            hold_last <= '0;
            word_cnt  <= '0;
            width_err <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (load) begin
                hold_data <= bus.MAC_TX_Data;
                hold_k    <= bus.MAC_TX_DataK;
                hold_last <= last_sel;
            end
            if ((state == SEND) && at_last) begin
                word_cnt <= word_cnt + 16'd1;
            end
            if (!legal) begin
                width_err <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.Enc_Data    = 8'h00;
        bus.Enc_DataK   = 1'b0;
        bus.Enc_Data_En = 1'b0;
        if (state == SEND) begin
            bus.Enc_Data    = hold_data[{idx, 3'b000} +: 8];
            bus.Enc_DataK   = hold_k[idx];
            bus.Enc_Data_En = 1'b1;
        end
    end

    assign bus.MAC_Data_Rdy = rdy;
    assign bus.Width_Err    = width_err;
    assign bus.Word_Cnt     = word_cnt;
endmodule

// File: tb/tb_tx_width_sequencer.sv
// Bench for tx_width_sequencer: directed and random MAC words checked against a
// byte-queue model of the expected encoder stream, ready, error and word count.
module tb_tx_width_sequencer;
    logic PCLK;
    logic Reset;

    tx_width_sequencer_if #(.DATA_WIDTH(32), .K_WIDTH(4)) bus ();

    tx_width_sequencer #(.DATA_WIDTH(32), .K_WIDTH(4)) dut (
        .PCLK  (PCLK),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [7:0] d;
        logic       k;
        logic       last;
    } ent_t;

    ent_t        q[$];
    logic [15:0] m_cnt;
    logic        m_err;
    int unsigned n_cmp;
    int unsigned n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int n_of(input logic [5:0] w);
        case (w)
            6'd8:    return 1;
            6'd16:   return 2;
            6'd32:   return 4;
            default: return 0;
        endcase
    endfunction

    task automatic model_clear();
        q.delete();
        m_cnt = '0;
        m_err = 1'b0;
    endtask

    // Called at a negedge: drive, check outputs, advance through posedge, back to negedge.
    task automatic step(input logic [5:0] w, input logic [31:0] d, input logic [3:0] k, input logic e);
        int  n;
        logic exp_rdy;
        bus.DataBusWidth = w;
        bus.MAC_TX_Data  = d;
        bus.MAC_TX_DataK = k;
        bus.MAC_Data_En  = e;
        n = n_of(w);
        exp_rdy = (n != 0) && (q.size() <= 1);
        #1;
        check("rdy",  bus.MAC_Data_Rdy, exp_rdy);
        check("en",   bus.Enc_Data_En,  q.size() > 0);
        check("data", bus.Enc_Data,     q.size() > 0 ? q[0].d : 8'h00);
        check("k",    bus.Enc_DataK,    q.size() > 0 ? q[0].k : 1'b0);
        check("werr", bus.Width_Err,    m_err);
        check("cnt",  bus.Word_Cnt,     m_cnt);
        @(posedge PCLK);
        if (q.size() > 0) begin
            if (q[0].last) m_cnt = m_cnt + 16'd1;
            void'(q.pop_front());
        end
        if (e && exp_rdy) begin
            for (int i = 0; i < n; i++) begin
                ent_t x;
                x.d    = d[8*i +: 8];
                x.k    = k[i];
                x.last = (i == n - 1);
                q.push_back(x);
            end
        end
        if (n == 0) m_err = 1'b1;
        @(negedge PCLK);
    endtask

    task automatic drain(input logic [5:0] w);
        int guard = 0;
        while (q.size() > 0 && guard < 16) begin
            step(w, 32'h0, 4'h0, 1'b0);
            guard++;
        end
        check("drain_bound", q.size(), 0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        bus.DataBusWidth = 6'd32;
        #1;
        check("rst_en",   bus.Enc_Data_En,  0);
        check("rst_data", bus.Enc_Data,     0);
        check("rst_k",    bus.Enc_DataK,    0);
        check("rst_rdy",  bus.MAC_Data_Rdy, 0);
        check("rst_werr", bus.Width_Err,    0);
        check("rst_cnt",  bus.Word_Cnt,     0);
        @(posedge PCLK);
        @(negedge PCLK);
        Reset = 1'b0;
        model_clear();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_clear();
        Reset = 1'b1;
        bus.DataBusWidth = 6'd32;
        bus.MAC_TX_Data  = '0;
        bus.MAC_TX_DataK = '0;
        bus.MAC_Data_En  = 1'b0;
        @(negedge PCLK);
        do_reset();

        // Single 32-bit word with K on byte 0
        step(6'd32, 32'h44332211, 4'b0001, 1'b1);
        drain(6'd32);
        step(6'd32, 32'h0, 4'h0, 1'b0);
        check("w32_cnt", bus.Word_Cnt, 1);

        // Width 8 streaming A0..A7
        do_reset();
        for (int i = 0; i < 8; i++) step(6'd8, 32'hFFFFFF00 | (32'hA0 + 32'(i)), 4'hE, 1'b1);
        drain(6'd8);
        check("w8_cnt", bus.Word_Cnt, 8);

        // Width 16 back-to-back
        do_reset();
        step(6'd16, 32'h1234BBAA, 4'b1100, 1'b1);
        step(6'd16, 32'h5678DDCC, 4'b1110, 1'b1);
        step(6'd16, 32'h5678DDCC, 4'b1110, 1'b1);
        drain(6'd16);
        check("w16_cnt", bus.Word_Cnt, 2);

        // Illegal width while a 32-bit word is in flight
        do_reset();
        step(6'd32, 32'hCAFEF00D, 4'b1010, 1'b1);
        for (int i = 0; i < 5; i++) step(6'd12, 32'h11111111, 4'hF, 1'b1);
        check("ill_cnt", bus.Word_Cnt, 1);
        for (int i = 0; i < 3; i++) step(6'd32, 32'h99887766, 4'h0, 1'b1);
        drain(6'd32);
        check("ill_sticky", bus.Width_Err, 1);

        // Reset mid-word at byte index 1
        do_reset();
        step(6'd32, 32'hDEADBEEF, 4'b0100, 1'b1);
        step(6'd32, 32'h0, 4'h0, 1'b0);
        Reset = 1'b1;
        #1;
        check("mid_rst_en",  bus.Enc_Data_En, 0);
        check("mid_rst_cnt", bus.Word_Cnt,    0);
        @(posedge PCLK);
        @(negedge PCLK);
        Reset = 1'b0;
        model_clear();
        step(6'd32, 32'h87654321, 4'b1000, 1'b1);
        drain(6'd32);

        // Random stimulus, occasional illegal widths
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [5:0] w;
            int unsigned pick;
            pick = $urandom_range(0, 29);
            if (pick == 0) w = 6'($urandom_range(0, 63));
            else if (pick % 3 == 0) w = 6'd8;
            else if (pick % 3 == 1) w = 6'd16;
            else w = 6'd32;
            step(w, $urandom, 4'($urandom), ($urandom_range(0, 9) < 7));
            if (c == 199) begin
                drain(6'd32);
                do_reset();
            end
        end
        drain(6'd32);

        // Word counter wrap
        do_reset();
        for (int i = 0; i < 65535; i++) step(6'd8, $urandom, 4'($urandom), 1'b1);
        drain(6'd8);
        step(6'd8, 32'h0, 4'h0, 1'b0);
        check("cnt_ffff", bus.Word_Cnt, 16'hFFFF);
        step(6'd8, 32'h5A, 4'h1, 1'b1);
        drain(6'd8);
        step(6'd8, 32'h0, 4'h0, 1'b0);
        check("cnt_wrap", bus.Word_Cnt, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
